// File: rtl/valtrain_detect_ctrl_if.sv
// VALTRAIN detection controller bus: requester side and pattern-detector side.
// master = requester/detector model, slave = controller.
interface valtrain_detect_ctrl_if;
  logic        i_start;
  logic        i_mode;
  logic [11:0] i_error_threshold;
  logic        i_abort;
  logic        i_det_result;
  logic        o_enable_detector;
  logic        o_enable_cons;
  logic        o_enable_128;
  logic [11:0] o_error_threshold;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [1:0]  o_retry_cnt;

  modport master (
    output i_start, i_mode, i_error_threshold,
    output i_abort, i_det_result,
    input  o_enable_detector, o_enable_cons,
    input  o_enable_128, o_error_threshold,
    input  o_busy, o_done, o_pass, o_retry_cnt
  );

  modport slave (
    input  i_start, i_mode, i_error_threshold,
    input  i_abort, i_det_result,
    output o_enable_detector, o_enable_cons,
    output o_enable_128, o_error_threshold,
    output o_busy, o_done, o_pass, o_retry_cnt
  );
endinterface

// File: rtl/valtrain_detect_ctrl.sv
// Sequences one valid-lane VALTRAIN detection run: CLEAR, RUN, SETTLE, REPORT.
// Optional macro VALTRAIN_RETRY_EN: retry failing verdicts up to MAX_RETRY times.
module valtrain_detect_ctrl #(
  parameter int ITER_COUNT    = 128,
  parameter int CONS_TIMEOUT  = 64,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  valtrain_detect_ctrl_if.slave  bus
);

`ifdef VALTRAIN_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  localparam int RunMax =
    (ITER_COUNT > CONS_TIMEOUT) ? ITER_COUNT
                                : CONS_TIMEOUT;
  localparam int CntW =
    $clog2(RunMax + SETTLE_CYCLES + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t IterLast =
    cnt_t'(ITER_COUNT - 1);
  localparam cnt_t ConsLast =
    cnt_t'(CONS_TIMEOUT - 1);
  localparam cnt_t IterSetLast =
    cnt_t'(ITER_COUNT + SETTLE_CYCLES - 1);
  localparam cnt_t ConsSetLast =
    cnt_t'(CONS_TIMEOUT + SETTLE_CYCLES - 1);
  localparam logic [1:0] RetryLim =
    2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_REPORT
  } state_t;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic [11:0] thr_q, thr_d;
  logic        pass_q, pass_d;
  logic [1:0]  retry_q, retry_d;

  logic run_last;
  logic settle_last;
  logic retry_ok;

  // End-of-window and end-of-settle decode for the latched mode
  always_comb begin
    run_last    = mode_q ? (cnt_q == ConsLast)
                         : (cnt_q == IterLast);
    settle_last = mode_q ? (cnt_q == ConsSetLast)
                         : (cnt_q == IterSetLast);
    retry_ok    = RetryEn && (retry_q < RetryLim);
  end

  // Next-state, counter and latched-run-context logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    thr_d   = thr_q;
    pass_d  = pass_q;
    retry_d = retry_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          mode_d  = bus.i_mode;
          thr_d   = bus.i_error_threshold;
          pass_d  = 1'b0;
          retry_d = 2'd0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d = '0;
        if (bus.i_abort) begin
          pass_d  = 1'b0;
          state_d = S_REPORT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (bus.i_abort) begin
          pass_d  = 1'b0;
          state_d = S_REPORT;
        end else if (mode_q && bus.i_det_result) begin
          pass_d  = 1'b1;
          state_d = S_REPORT;
        end else if (run_last) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (bus.i_abort) begin
          pass_d  = 1'b0;
          state_d = S_REPORT;
        end else if (mode_q && bus.i_det_result) begin
          pass_d  = 1'b1;
          state_d = S_REPORT;
        end else if (settle_last) begin
          if (bus.i_det_result) begin
            pass_d  = 1'b1;
            state_d = S_REPORT;
          end else if (retry_ok) begin
            retry_d = retry_q + 2'd1;
            state_d = S_CLEAR;
          end else begin
            pass_d  = 1'b0;
            state_d = S_REPORT;
          end
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and context registers, synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      thr_q   <= '0;
      pass_q  <= 1'b0;
      retry_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      pass_q  <= pass_d;
      retry_q <= retry_d;
    end
  end

  logic active;
  assign active = (state_q == S_RUN) ||
                  (state_q == S_SETTLE);

  assign bus.o_enable_detector =
    (state_q == S_CLEAR) || active;
  assign bus.o_enable_128  = active && !mode_q;
  assign bus.o_enable_cons = active && mode_q;
  assign bus.o_error_threshold = thr_q;
  assign bus.o_busy = (state_q != S_IDLE);
  assign bus.o_done = (state_q == S_REPORT);
  assign bus.o_pass = pass_q;
  assign bus.o_retry_cnt =
    RetryEn ? retry_q : 2'd0;

endmodule

// File: tb/tb_valtrain_detect_ctrl.sv
// Directed self-checking bench for valtrain_detect_ctrl.
// Cycle 0 is the cycle whose rising edge accepts i_start.
module tb_valtrain_detect_ctrl;

`ifdef VALTRAIN_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  valtrain_detect_ctrl_if bus();

  valtrain_detect_ctrl dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  int done_cyc, last_done, done_n;
  int pass_at, retry_at;
  int n128, ncons, thr_bad;
  int c_det, c_cons, c_128, c_pass;

  // det_kind: 0 low, 1 high, 2 high from det_at, 3 high except det_at
  task automatic run(input logic mode,
                     input logic [11:0] thr,
                     input int det_kind,
                     input int det_at,
                     input int abort_at,
                     input int budget,
                     input bit hold);
    done_cyc = -1; last_done = -1; done_n = 0;
    pass_at = -1; retry_at = -1;
    n128 = 0; ncons = 0; thr_bad = 0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_mode = mode;
    bus.i_error_threshold = thr;
    bus.i_abort = 1'b0;
    bus.i_det_result = (det_kind == 1) || (det_kind == 3);
    @(posedge clk);
    #1;
    if (!hold) bus.i_start = 1'b0;
    bus.i_error_threshold = ~thr;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        c_det = int'(bus.o_enable_detector);
        c_cons = int'(bus.o_enable_cons);
        c_128 = int'(bus.o_enable_128);
        c_pass = int'(bus.o_pass);
      end
      if (bus.o_done) begin
        done_n++;
        last_done = k;
        if (done_cyc < 0) begin
          done_cyc = k;
          pass_at = int'(bus.o_pass);
          retry_at = int'(bus.o_retry_cnt);
        end
      end
      if (bus.o_enable_128) n128++;
      if (bus.o_enable_cons) ncons++;
      if (bus.o_busy && bus.o_error_threshold !== thr)
        thr_bad++;
      unique case (det_kind)
        0: bus.i_det_result = 1'b0;
        1: bus.i_det_result = 1'b1;
        2: bus.i_det_result = (k >= det_at);
        default: bus.i_det_result = (k != det_at);
      endcase
      bus.i_abort = (k == abort_at);
      if (!hold) bus.i_start = (k == abort_at);
    end
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_det_result = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_pass} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got %b want 000",
               {bus.o_busy, bus.o_done, bus.o_pass});
    end
    checks++;
    if ({bus.o_enable_detector, bus.o_enable_cons,
         bus.o_enable_128} !== 3'b000) begin
      errors++;
      $display("FAIL reset_enables: got %b want 000",
               {bus.o_enable_detector, bus.o_enable_cons,
                bus.o_enable_128});
    end
    checks++;
    if ({bus.o_error_threshold, bus.o_retry_cnt} !== 14'd0) begin
      errors++;
      $display("FAIL reset_thr_retry: got %h want 0",
               {bus.o_error_threshold, bus.o_retry_cnt});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_pass();
    run(1'b0, 12'h010, 1, 0, 0, 160, 1'b0);
    checks++;
    if ({c_det, c_cons, c_128} !== {32'd1, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL m0_clear_enables: got %0d%0d%0d want 100",
               c_det, c_cons, c_128);
    end
    checks++;
    if (n128 !== 130 || ncons !== 0) begin
      errors++;
      $display("FAIL m0_en128_cycles: got %0d/%0d want 130/0",
               n128, ncons);
    end
    checks++;
    if (done_cyc !== 132 || done_n !== 1) begin
      errors++;
      $display("FAIL m0_pass_latency: got %0d x%0d want 132 x1",
               done_cyc, done_n);
    end
    checks++;
    if (pass_at !== 1 || retry_at !== 0) begin
      errors++;
      $display("FAIL m0_pass_flag: got %0d/%0d want 1/0",
               pass_at, retry_at);
    end
    checks++;
    if (bus.o_pass !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL m0_pass_hold: got %b%b want 10",
               bus.o_pass, bus.o_busy);
    end
  endtask

  task automatic test_mode0_fail();
    int exp_done;
    exp_done = RETRY ? 263 : 132;
    run(1'b0, 12'h010, 3, 131, 0, 300, 1'b0);
    checks++;
    if (c_pass !== 0) begin
      errors++;
      $display("FAIL m0f_pass_cleared: got %0d want 0", c_pass);
    end
    checks++;
    if (done_cyc !== exp_done || done_n !== 1) begin
      errors++;
      $display("FAIL m0f_latency: got %0d x%0d want %0d x1",
               done_cyc, done_n, exp_done);
    end
    checks++;
    if (pass_at !== int'(RETRY) || retry_at !== int'(RETRY)) begin
      errors++;
      $display("FAIL m0f_verdict: got %0d/%0d want %0d/%0d",
               pass_at, retry_at, RETRY, RETRY);
    end
    checks++;
    if (thr_bad !== 0) begin
      errors++;
      $display("FAIL m0f_threshold: got %0d bad want 0", thr_bad);
    end
  endtask

  task automatic test_mode1_pass();
    run(1'b1, 12'h000, 2, 21, 0, 40, 1'b0);
    checks++;
    if (done_cyc !== 22 || pass_at !== 1) begin
      errors++;
      $display("FAIL m1_pass: got %0d/%0d want 22/1",
               done_cyc, pass_at);
    end
    checks++;
    if (ncons !== 20 || n128 !== 0) begin
      errors++;
      $display("FAIL m1_cons_cycles: got %0d/%0d want 20/0",
               ncons, n128);
    end
  endtask

  task automatic test_mode1_timeout();
    int exp_done, exp_cons;
    exp_done = RETRY ? 269 : 68;
    exp_cons = RETRY ? 264 : 66;
    run(1'b1, 12'h000, 0, 0, 0, 300, 1'b0);
    checks++;
    if (done_cyc !== exp_done || pass_at !== 0) begin
      errors++;
      $display("FAIL m1_timeout: got %0d/%0d want %0d/0",
               done_cyc, pass_at, exp_done);
    end
    checks++;
    if (ncons !== exp_cons || done_n !== 1) begin
      errors++;
      $display("FAIL m1_timeout_cons: got %0d x%0d want %0d x1",
               ncons, done_n, exp_cons);
    end
  endtask

  task automatic test_abort();
    run(1'b0, 12'h3a5, 1, 0, 51, 100, 1'b0);
    checks++;
    if (done_cyc !== 52 || pass_at !== 0) begin
      errors++;
      $display("FAIL abort_report: got %0d/%0d want 52/0",
               done_cyc, pass_at);
    end
    checks++;
    if (done_n !== 1 || n128 !== 50 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_ignored: got %0d/%0d/%b want 1/50/0",
               done_n, n128, bus.o_busy);
    end
    run(1'b1, 12'h000, 2, 11, 11, 30, 1'b0);
    checks++;
    if (done_cyc !== 12 || pass_at !== 0) begin
      errors++;
      $display("FAIL abort_priority: got %0d/%0d want 12/0",
               done_cyc, pass_at);
    end
  endtask

  task automatic test_mid_reset();
    int dn;
    dn = 0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_mode = 1'b0;
    bus.i_error_threshold = 12'h0ff;
    bus.i_det_result = 1'b1;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.o_busy, bus.o_done, bus.o_pass,
         bus.o_enable_detector, bus.o_enable_cons,
         bus.o_enable_128, bus.o_retry_cnt,
         bus.o_error_threshold} !== 20'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h want 0",
               {bus.o_busy, bus.o_done, bus.o_pass,
                bus.o_enable_detector, bus.o_enable_cons,
                bus.o_enable_128, bus.o_retry_cnt,
                bus.o_error_threshold});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.o_done || bus.o_busy) dn++;
    end
    bus.i_det_result = 1'b0;
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d active want 0", dn);
    end
  endtask

  task automatic test_back_to_back();
    run(1'b1, 12'h001, 1, 0, 0, 8, 1'b1);
    checks++;
    if (done_n !== 2 || done_cyc !== 3 || last_done !== 7) begin
      errors++;
      $display("FAIL b2b_dones: got %0d@%0d,%0d want 2@3,7",
               done_n, done_cyc, last_done);
    end
    checks++;
    if (pass_at !== 1 || retry_at !== 0) begin
      errors++;
      $display("FAIL b2b_pass: got %0d/%0d want 1/0",
               pass_at, retry_at);
    end
  endtask

  task automatic test_retry();
    int exp_done, exp_retry;
    exp_done = RETRY ? 525 : 132;
    exp_retry = RETRY ? 3 : 0;
    run(1'b0, 12'h020, 0, 0, 0, 600, 1'b0);
    checks++;
    if (done_cyc !== exp_done || done_n !== 1) begin
      errors++;
      $display("FAIL retry_latency: got %0d x%0d want %0d x1",
               done_cyc, done_n, exp_done);
    end
    checks++;
    if (retry_at !== exp_retry || pass_at !== 0) begin
      errors++;
      $display("FAIL retry_count: got %0d/%0d want %0d/0",
               retry_at, pass_at, exp_retry);
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    bus.i_mode = 1'b0;
    bus.i_error_threshold = 12'h000;
    bus.i_abort = 1'b0;
    bus.i_det_result = 1'b0;
    test_reset();
    test_mode0_pass();
    test_mode0_fail();
    test_mode1_pass();
    test_mode1_timeout();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    test_retry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             checks, errors);
    $finish;
  end

endmodule
